sdram_req_bridge: RTL and testbench
===================================

# sdram_req_bridge

Parametrised bridge from NCH byte-wide bus masters (CPU, FDC, loaders) to a toggle-handshake SDRAM controller, one controller port per channel. It generalises the inline strobe-to-request logic in the machine top level. Each channel has edge and address-change triggers, a one-deep pending slot, byte-lane select, read-data capture and a busy/overrun status. It sits between the machine core and `sdram`, in the SDRAM clock domain.

## Interface
Parameters:
- NCH, 2, number of independent channels
- AW, 16, channel byte-address width; port word address is AW-1 bits

Ports:
- clk  in  1  SDRAM-domain clock (clk_72 in current tops)
- reset  in  1  synchronous, active-high
- ch_cs  in  NCH  channel select
- ch_oe  in  NCH  read strobe
- ch_we  in  NCH  write strobe
- ch_a  in  NCH*AW  byte address, channel i at [i*AW +: AW]
- ch_d  in  NCH*8  write data
- ch_q  out  NCH*8  read data; 0 while ch_cs[i]=0
- ch_busy  out  NCH  request outstanding or pending
- ch_overrun  out  NCH  sticky: a pending request was overwritten
- port_req  out  NCH  toggle request to controller
- port_ack  in  NCH  toggle acknowledge from controller
- port_a  out  NCH*(AW-1)  word address, ch_a[AW-1:1]
- port_ds  out  NCH*2  byte enables
- port_we  out  NCH  write
- port_d  out  NCH*16  {d,d}
- port_q  in  NCH*16  controller read data

## Operation
- Channel i is idle when port_req[i]==port_ack[i] and the pending slot is empty.
- Trigger: rising (cs&oe), rising (cs&we), or address change while cs&oe (see Configuration). Compare against the previous-cycle registered cs, oe, we and a.
- Descriptor latched on trigger: word address, we, data, ds.
  - Write: ds=2'b10 if a[0]=1, else 2'b01.
  - Read: ds=2'b11.
- Trigger while idle: descriptor drives port_* and port_req[i] toggles.
- Trigger while outstanding: descriptor goes to the pending slot. If the slot is already full, the new descriptor overwrites it and ch_overrun[i] is set.
- Ack detected (port_ack[i] becomes equal to port_req[i]): if the request was a read, ch_q byte is port_q[15:8] if a[0]=1, else [7:0]. The byte is held until the next read completes.
- Pending slot non-empty at ack: it is issued the following cycle and the slot is cleared.
- Simultaneous trigger and ack: the ack is processed first. The trigger is then issued the next cycle, behaving exactly as pending.
- Channels are fully independent, with no shared state.
- Reset:
  - port_req is forced equal to port_ack.
  - Pending slot is cleared; ch_q=0; ch_overrun=0; port_we=0; port_ds=0; port_a=0; port_d=0.
  - Previous-sample registers track the live inputs, so a strobe held across reset release does not trigger.
  - Reset must be held longer than the controller's worst-case latency so that in-flight requests complete.

## Timing
- Strobe sampled at edge N produces a port_req toggle and a valid port_a/ds/we/d after edge N (1 cycle).
- port_a, ds, we and d are stable from the toggle until the matching ack.
- Ack sampled at edge M: ch_q is valid after M. ch_busy falls after M if no request is pending.
- Pending request issued after edge M+1.
- ch_busy rises after the trigger edge.
- ch_overrun clears only on reset.

## Configuration
- SDRAM_REQ_ADDR_CHANGE_EN defined: an address change while cs&oe remain high is a read trigger. This supports masters that hold oe across consecutive reads, e.g. video/CPU fetch.
- SDRAM_REQ_ADDR_CHANGE_EN undefined: only rising cs&oe and rising cs&we trigger, and address registers are not compared.

## Test plan
- Read ch0: cs=oe=1, a=16'h1235; model acks after 5 clk with port_q=16'hAB12. Required: port_req toggles 1 cycle after the strobe, port_a=15'h091A, ds=2'b11, ch_q=8'hAB the cycle after ack, ch_busy low.
- Write ch1: a=16'h0400, d=8'h5A. Required: port_we=1, ds=2'b01, port_d=16'h5A5A, one toggle only.
- Back-to-back: three write triggers during one outstanding read with slow ack. Required: the third descriptor is issued after ack, the second is lost, ch_overrun=1.
- Address change with macro defined: oe held, a steps 16'h0010 to 16'h0011 to 16'h0012. Required: 3 requests. Without macro: 1 request.
- Trigger in the same cycle as ack. Required: the new request issues exactly 1 cycle later and ch_q updates from the old ack.
- Reset with cs=oe=1 held. Required: after release there is no toggle, port_req==port_ack, all outputs at reset values, and the channels remain independent.

Source files
------------

// File: rtl/sdram_req_bridge.sv
// sdram_req_bridge
// Bridges NCH byte-wide bus masters onto toggle-handshake SDRAM controller
// ports, one port per channel. Each channel turns strobe edges into word
// requests, keeps a one-deep pending slot, captures read bytes and reports
// busy/overrun. All logic runs in the SDRAM clock domain.
//
// Build option: define SDRAM_REQ_ADDR_CHANGE_EN to make an address change
// while cs&oe stay high count as a new read trigger.

module sdram_req_bridge #(
  parameter int NCH = 2,
  parameter int AW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         ch_cs,
  input  logic [NCH-1:0]         ch_oe,
  input  logic [NCH-1:0]         ch_we,
  input  logic [NCH*AW-1:0]      ch_a,
  input  logic [NCH*8-1:0]       ch_d,
  output logic [NCH*8-1:0]       ch_q,
  output logic [NCH-1:0]         ch_busy,
  output logic [NCH-1:0]         ch_overrun,
  output logic [NCH-1:0]         port_req,
  input  logic [NCH-1:0]         port_ack,
  output logic [NCH*(AW-1)-1:0]  port_a,
  output logic [NCH*2-1:0]       port_ds,
  output logic [NCH-1:0]         port_we,
  output logic [NCH*16-1:0]      port_d,
  input  logic [NCH*16-1:0]      port_q
);

  genvar gi;

  for (gi = 0; gi < NCH; gi++) begin : g_ch
    // live channel inputs
    logic [AW-1:0] a_in;
    logic [7:0]    d_in;
    logic [15:0]   q_in;

    assign a_in = ch_a[gi*AW +: AW];
    assign d_in = ch_d[gi*8 +: 8];
    assign q_in = port_q[gi*16 +: 16];

    // previous-cycle samples for edge detection
    logic cs_prev_reg;
    logic oe_prev_reg;
    logic we_prev_reg;

    // handshake state
    logic req_reg;
    logic inflight_reg;

    // descriptor currently presented to the controller
    logic [AW-2:0] cur_a_reg;
    logic [1:0]    cur_ds_reg;
    logic          cur_we_reg;
    logic [7:0]    cur_d_reg;
    logic          cur_lsb_reg;

    // one-deep pending slot
    logic          pend_valid_reg;
    logic [AW-2:0] pend_a_reg;
    logic [1:0]    pend_ds_reg;
    logic          pend_we_reg;
    logic [7:0]    pend_d_reg;
    logic          pend_lsb_reg;

    // status
    logic [7:0] q_reg;
    logic       overrun_reg;

    // decode results
    logic          rd_now;
    logic          rd_prev;
    logic          wr_now;
    logic          wr_prev;
    logic          rd_trig;
    logic          wr_trig;
    logic          addr_trig;
    logic          trig;
    logic          ack_seen;
    logic          issue_pend;
    logic          issue_new;
    logic          to_slot;
    logic          slot_overwrite;
    logic [AW-2:0] new_a;
    logic [1:0]    new_ds;
    logic          new_we;
    logic [7:0]    new_d;
    logic          new_lsb;

    assign rd_now  = ch_cs[gi] & ch_oe[gi];
    assign wr_now  = ch_cs[gi] & ch_we[gi];
    assign rd_prev = cs_prev_reg & oe_prev_reg;
    assign wr_prev = cs_prev_reg & we_prev_reg;

`ifdef SDRAM_REQ_ADDR_CHANGE_EN
    logic [AW-1:0] a_prev_reg;

    // Address sample for detecting a new read while oe is held; it follows
    // the live address during reset as well.
    always_ff @(posedge clk) begin
      a_prev_reg <= a_in;
    end

    assign addr_trig = rd_now & rd_prev & (a_in != a_prev_reg);
`else
    assign addr_trig = 1'b0;
`endif

    // Trigger decode, descriptor build and issue/slot decisions.
    always_comb begin
      rd_trig        = rd_now & ~rd_prev;
      wr_trig        = wr_now & ~wr_prev;
      trig           = rd_trig | wr_trig | addr_trig;
      // A write edge wins if both strobes rise together.
      new_we         = wr_trig;
      new_a          = a_in[AW-1:1];
      new_d          = d_in;
      new_lsb        = a_in[0];
      new_ds         = 2'b11;
      if (wr_trig) begin
        new_ds = a_in[0] ? 2'b10 : 2'b01;
      end
      ack_seen       = inflight_reg & (port_ack[gi] == req_reg);
      // The slot drains one cycle after the ack that freed the port.
      issue_pend     = pend_valid_reg & ~inflight_reg;
      issue_new      = trig & ~inflight_reg & ~pend_valid_reg;
      // An ack arriving with a trigger still counts as busy: the trigger is
      // parked and issued next cycle, exactly like a pending request.
      to_slot        = trig & ~issue_new;
      slot_overwrite = to_slot & pend_valid_reg & ~issue_pend;
    end

    // Channel state: edge samples, handshake, descriptor, slot and status.
    always_ff @(posedge clk) begin
      cs_prev_reg <= ch_cs[gi];
      oe_prev_reg <= ch_oe[gi];
      we_prev_reg <= ch_we[gi];
      if (reset) begin
        req_reg        <= port_ack[gi];
        inflight_reg   <= 1'b0;
        cur_a_reg      <= '0;
        cur_ds_reg     <= 2'b00;
        cur_we_reg     <= 1'b0;
        cur_d_reg      <= 8'h00;
        cur_lsb_reg    <= 1'b0;
        pend_valid_reg <= 1'b0;
        pend_a_reg     <= '0;
        pend_ds_reg    <= 2'b00;
        pend_we_reg    <= 1'b0;
        pend_d_reg     <= 8'h00;
        pend_lsb_reg   <= 1'b0;
        q_reg          <= 8'h00;
        overrun_reg    <= 1'b0;
      end else begin
        if (ack_seen) begin
          inflight_reg <= 1'b0;
          if (!cur_we_reg) begin
            q_reg <= cur_lsb_reg ? q_in[15:8] : q_in[7:0];
          end
        end

        if (issue_pend) begin
          cur_a_reg    <= pend_a_reg;
          cur_ds_reg   <= pend_ds_reg;
          cur_we_reg   <= pend_we_reg;
          cur_d_reg    <= pend_d_reg;
          cur_lsb_reg  <= pend_lsb_reg;
          req_reg      <= ~req_reg;
          inflight_reg <= 1'b1;
        end else if (issue_new) begin
          cur_a_reg    <= new_a;
          cur_ds_reg   <= new_ds;
          cur_we_reg   <= new_we;
          cur_d_reg    <= new_d;
          cur_lsb_reg  <= new_lsb;
          req_reg      <= ~req_reg;
          inflight_reg <= 1'b1;
        end

        if (to_slot) begin
          pend_valid_reg <= 1'b1;
          pend_a_reg     <= new_a;
          pend_ds_reg    <= new_ds;
          pend_we_reg    <= new_we;
          pend_d_reg     <= new_d;
          pend_lsb_reg   <= new_lsb;
        end else if (issue_pend) begin
          pend_valid_reg <= 1'b0;
        end

        if (slot_overwrite) begin
          overrun_reg <= 1'b1;
        end
      end
    end

    assign port_req[gi]              = req_reg;
    assign port_a[gi*(AW-1) +: AW-1] = cur_a_reg;
    assign port_ds[gi*2 +: 2]        = cur_ds_reg;
    assign port_we[gi]               = cur_we_reg;
    assign port_d[gi*16 +: 16]       = {cur_d_reg, cur_d_reg};
    assign ch_q[gi*8 +: 8]           = ch_cs[gi] ? q_reg : 8'h00;
    assign ch_busy[gi]               = inflight_reg | pend_valid_reg;
    assign ch_overrun[gi]            = overrun_reg;
  end

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed testbench for sdram_req_bridge with a small toggle-ack
// controller model per channel.

`timescale 1ns/1ps

module tb_sdram_req_bridge;
  localparam int NCH = 2;
  localparam int AW  = 16;

`ifdef SDRAM_REQ_ADDR_CHANGE_EN
  localparam int ADDR_CHG_REQS = 3;
`else
  localparam int ADDR_CHG_REQS = 1;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NCH-1:0]        ch_cs = '0;
  logic [NCH-1:0]        ch_oe = '0;
  logic [NCH-1:0]        ch_we = '0;
  logic [NCH*AW-1:0]     ch_a = '0;
  logic [NCH*8-1:0]      ch_d = '0;
  logic [NCH*8-1:0]      ch_q;
  logic [NCH-1:0]        ch_busy;
  logic [NCH-1:0]        ch_overrun;
  logic [NCH-1:0]        port_req;
  logic [NCH-1:0]        port_ack = '0;
  logic [NCH*(AW-1)-1:0] port_a;
  logic [NCH*2-1:0]      port_ds;
  logic [NCH-1:0]        port_we;
  logic [NCH*16-1:0]     port_d;
  logic [NCH*16-1:0]     port_q = '0;

  int checks = 0;
  int errors = 0;
  int dly[NCH] = '{default: 2};
  int cnt[NCH] = '{default: 0};
  logic [NCH-1:0] ack_now = '0;
  int tog[NCH] = '{default: 0};
  logic [NCH-1:0] req_last = '0;
  int t0;
  int t1;

  sdram_req_bridge #(.NCH(NCH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_cs      (ch_cs),
    .ch_oe      (ch_oe),
    .ch_we      (ch_we),
    .ch_a       (ch_a),
    .ch_d       (ch_d),
    .ch_q       (ch_q),
    .ch_busy    (ch_busy),
    .ch_overrun (ch_overrun),
    .port_req   (port_req),
    .port_ack   (port_ack),
    .port_a     (port_a),
    .port_ds    (port_ds),
    .port_we    (port_we),
    .port_d     (port_d),
    .port_q     (port_q)
  );

  always #5 clk = ~clk;

  // Controller model: acks dly cycles after seeing a new toggle, or at once on ack_now.
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (port_req[i] != port_ack[i]) begin
        if (ack_now[i] || cnt[i] >= dly[i] - 1) begin
          port_ack[i] <= port_req[i];
          cnt[i] <= 0;
        end else begin
          cnt[i] <= cnt[i] + 1;
        end
      end else begin
        cnt[i] <= 0;
      end
    end
  end

  // Count request toggles per channel.
  always @(port_req) begin
    for (int i = 0; i < NCH; i++) begin
      if (port_req[i] !== req_last[i]) tog[i] = tog[i] + 1;
    end
    req_last = port_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (8) step();
    reset = 1'b0;
    step();
    check("rst_req_eq_ack", {30'd0, port_req}, {30'd0, port_ack});
    check("rst_ch_q", {16'd0, ch_q}, 32'h0);
    check("rst_busy", {30'd0, ch_busy}, 32'h0);
    check("rst_overrun", {30'd0, ch_overrun}, 32'h0);
    check("rst_port_ds", {28'd0, port_ds}, 32'h0);
    check("rst_port_a", {2'd0, port_a}, 32'h0);
    check("rst_port_d", port_d, 32'h0);

    // ---------------- read ch0 ----------------
    dly[0] = 5;
    port_q[15:0] = 16'hAB12;
    ch_cs[0] = 1'b1; ch_oe[0] = 1'b1; ch_a[15:0] = 16'h1235;
    t0 = tog[0];
    step();
    check("rd_toggle", tog[0] - t0, 1);
    check("rd_port_a", {17'd0, port_a[14:0]}, 32'h091A);
    check("rd_port_ds", {30'd0, port_ds[1:0]}, 32'h3);
    check("rd_port_we", {31'd0, port_we[0]}, 32'h0);
    check("rd_busy_rise", {31'd0, ch_busy[0]}, 32'h1);
    repeat (5) step();
    check("rd_busy_wait", {31'd0, ch_busy[0]}, 32'h1);
    check("rd_q_wait", {24'd0, ch_q[7:0]}, 32'h0);
    step();
    check("rd_q", {24'd0, ch_q[7:0]}, 32'hAB);
    check("rd_busy_fall", {31'd0, ch_busy[0]}, 32'h0);
    check("rd_one_toggle", tog[0] - t0, 1);
    check("rd_req_eq_ack", {31'd0, port_req[0]}, {31'd0, port_ack[0]});
    ch_oe[0] = 1'b0; step();
    ch_cs[0] = 1'b0; step();
    check("rd_q_cs_low", {24'd0, ch_q[7:0]}, 32'h0);

    // ---------------- write ch1 ----------------
    dly[1] = 3;
    ch_cs[1] = 1'b1; ch_we[1] = 1'b1; ch_a[31:16] = 16'h0400; ch_d[15:8] = 8'h5A;
    t0 = tog[0]; t1 = tog[1];
    step();
    check("wr_port_we", {31'd0, port_we[1]}, 32'h1);
    check("wr_port_ds", {30'd0, port_ds[3:2]}, 32'h1);
    check("wr_port_d", {16'd0, port_d[31:16]}, 32'h5A5A);
    check("wr_port_a", {17'd0, port_a[29:15]}, 32'h0200);
    check("wr_busy", {31'd0, ch_busy[1]}, 32'h1);
    repeat (6) step();
    check("wr_one_toggle", tog[1] - t1, 1);
    check("wr_busy_fall", {31'd0, ch_busy[1]}, 32'h0);
    check("wr_q_unchanged", {24'd0, ch_q[15:8]}, 32'h0);
    check("wr_ch0_quiet", tog[0] - t0, 0);
    ch_we[1] = 1'b0; ch_cs[1] = 1'b0; step();

    // ---------------- back-to-back on ch0 ----------------
    dly[0] = 1000;
    port_q[15:0] = 16'hC3D4;
    ch_cs[0] = 1'b1; ch_oe[0] = 1'b1; ch_a[15:0] = 16'h0020;
    t0 = tog[0];
    step();
    check("b2b_read_toggle", tog[0] - t0, 1);
    ch_oe[0] = 1'b0; ch_we[0] = 1'b1; ch_a[15:0] = 16'h0031; ch_d[7:0] = 8'h11;
    step();
    check("b2b_first_no_overrun", {31'd0, ch_overrun[0]}, 32'h0);
    ch_we[0] = 1'b0; step();
    ch_we[0] = 1'b1; ch_a[15:0] = 16'h0040; ch_d[7:0] = 8'h22;
    step();
    check("b2b_overrun", {31'd0, ch_overrun[0]}, 32'h1);
    ch_we[0] = 1'b0; step();
    ch_we[0] = 1'b1; ch_a[15:0] = 16'h0053; ch_d[7:0] = 8'h33;
    step();
    ch_we[0] = 1'b0; step();
    check("b2b_no_extra_toggle", tog[0] - t0, 1);
    check("b2b_read_a_stable", {17'd0, port_a[14:0]}, 32'h0010);
    check("b2b_read_ds_stable", {30'd0, port_ds[1:0]}, 32'h3);
    ack_now[0] = 1'b1; step();
    ack_now[0] = 1'b0; step();
    check("b2b_read_q", {24'd0, ch_q[7:0]}, 32'hD4);
    check("b2b_hold_toggle", tog[0] - t0, 1);
    check("b2b_busy_pending", {31'd0, ch_busy[0]}, 32'h1);
    step();
    check("b2b_issue_toggle", tog[0] - t0, 2);
    check("b2b_third_a", {17'd0, port_a[14:0]}, 32'h0029);
    check("b2b_third_ds", {30'd0, port_ds[1:0]}, 32'h2);
    check("b2b_third_d", {16'd0, port_d[15:0]}, 32'h3333);
    check("b2b_third_we", {31'd0, port_we[0]}, 32'h1);
    ack_now[0] = 1'b1; step();
    ack_now[0] = 1'b0; step();
    check("b2b_busy_fall", {31'd0, ch_busy[0]}, 32'h0);
    check("b2b_overrun_sticky", {31'd0, ch_overrun[0]}, 32'h1);
    check("b2b_q_after_write", {24'd0, ch_q[7:0]}, 32'hD4);
    check("b2b_total_toggles", tog[0] - t0, 2);
    ch_cs[0] = 1'b0;

    // ---------------- address change on ch1 ----------------
    dly[1] = 2;
    port_q[31:16] = 16'h7788;
    ch_cs[1] = 1'b1; ch_oe[1] = 1'b1; ch_a[31:16] = 16'h0010;
    t1 = tog[1];
    repeat (6) step();
    ch_a[31:16] = 16'h0011;
    repeat (6) step();
    ch_a[31:16] = 16'h0012;
    repeat (6) step();
    check("addr_chg_requests", tog[1] - t1, ADDR_CHG_REQS);
    check("addr_chg_busy", {31'd0, ch_busy[1]}, 32'h0);
    check("addr_chg_q", {24'd0, ch_q[15:8]}, 32'h88);
    ch_oe[1] = 1'b0; step();

    // ---------------- trigger coincident with ack on ch1 ----------------
    dly[1] = 1000;
    port_q[31:16] = 16'hE5F6;
    ch_oe[1] = 1'b1; ch_a[31:16] = 16'h0101;
    t1 = tog[1];
    step();
    check("sim_read_toggle", tog[1] - t1, 1);
    ch_oe[1] = 1'b0; step();
    ack_now[1] = 1'b1; step();
    ack_now[1] = 1'b0;
    ch_we[1] = 1'b1; ch_a[31:16] = 16'h0202; ch_d[15:8] = 8'h9C;
    step();
    check("sim_q_old_ack", {24'd0, ch_q[15:8]}, 32'hE5);
    check("sim_not_yet", tog[1] - t1, 1);
    check("sim_busy", {31'd0, ch_busy[1]}, 32'h1);
    check("sim_no_overrun", {31'd0, ch_overrun[1]}, 32'h0);
    step();
    check("sim_issue", tog[1] - t1, 2);
    check("sim_port_a", {17'd0, port_a[29:15]}, 32'h0101);
    check("sim_port_we", {31'd0, port_we[1]}, 32'h1);
    check("sim_port_ds", {30'd0, port_ds[3:2]}, 32'h1);
    check("sim_port_d", {16'd0, port_d[31:16]}, 32'h9C9C);
    ch_we[1] = 1'b0;
    ack_now[1] = 1'b1; step();
    ack_now[1] = 1'b0; step();
    check("sim_busy_fall", {31'd0, ch_busy[1]}, 32'h0);

    // ---------------- reset with strobes held ----------------
    dly[0] = 2; dly[1] = 2;
    ch_cs = 2'b11; ch_oe = 2'b11; ch_we = 2'b00;
    ch_a[15:0] = 16'h0077; ch_a[31:16] = 16'h0088;
    reset = 1'b1;
    repeat (10) step();
    reset = 1'b0;
    t0 = tog[0]; t1 = tog[1];
    repeat (4) step();
    check("hold_no_toggle0", tog[0] - t0, 0);
    check("hold_no_toggle1", tog[1] - t1, 0);
    check("hold_req_eq_ack", {30'd0, port_req}, {30'd0, port_ack});
    check("hold_ch_q", {16'd0, ch_q}, 32'h0);
    check("hold_overrun", {30'd0, ch_overrun}, 32'h0);
    check("hold_busy", {30'd0, ch_busy}, 32'h0);
    check("hold_port_ds", {28'd0, port_ds}, 32'h0);
    check("hold_port_we", {30'd0, port_we}, 32'h0);
    check("hold_port_a", {2'd0, port_a}, 32'h0);
    check("hold_port_d", port_d, 32'h0);
    ch_oe[1] = 1'b0; step();
    ch_oe[1] = 1'b1; step();
    check("indep_toggle1", tog[1] - t1, 1);
    check("indep_toggle0", tog[0] - t0, 0);
    check("indep_busy", {30'd0, ch_busy}, 32'h2);
    repeat (5) step();
    check("indep_busy_fall", {30'd0, ch_busy}, 32'h0);
    check("indep_q1", {24'd0, ch_q[15:8]}, 32'hF6);
    check("indep_q0", {24'd0, ch_q[7:0]}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
